// File: rtl/orsram_seq_ctrl_if.sv
`default_nettype none
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif
// ============================================================================
// Module   : orsram_seq_ctrl_if
// Desc     : Stream, readback and SRAM-bank signal bundle for orsram_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface orsram_seq_ctrl_if #(
    parameter int NUM    = `SRAM_NUM,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) ();
    logic                     start;
    logic [ADDR_W-1:0]        frame_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM*DATA_W-1:0]    in_data;
    logic [NUM-1:0]           in_mask;
    logic                     wr_done;
    logic                     rd_start;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM*DATA_W-1:0]    out_data;
    logic                     rd_done;
    logic                     busy;
    logic                     sram_cen;
    logic [NUM-1:0]           sram_wen;
    logic [NUM*ADDR_W-1:0]    sram_a;
    logic [NUM*DATA_W-1:0]    sram_d;
    logic [NUM*DATA_W-1:0]    sram_q;

    // master: producer/consumer environment plus the SRAM array read port
    modport master (
        output start, frame_len, in_valid, in_data, in_mask, rd_start, out_ready, sram_q,
        input  in_ready, wr_done, out_valid, out_data, rd_done, busy,
               sram_cen, sram_wen, sram_a, sram_d
    );

    modport slave (
        input  start, frame_len, in_valid, in_data, in_mask, rd_start, out_ready, sram_q,
        output in_ready, wr_done, out_valid, out_data, rd_done, busy,
               sram_cen, sram_wen, sram_a, sram_d
    );
endinterface
`default_nettype wire

// File: rtl/orsram_seq_ctrl.sv
`default_nettype none
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif
// ============================================================================
// Module   : orsram_seq_ctrl
// Desc     : Writes one frame into the output-result SRAM banks, then streams it
//            back through a credit-controlled 4-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module orsram_seq_ctrl #(
    parameter int NUM    = `SRAM_NUM,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    orsram_seq_ctrl_if.slave   bus
);

    localparam int                 c_CNT_W   = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam int                 c_WORD_W  = NUM * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_CNT_W-1:0]     r_len;
    logic [c_CNT_W-1:0]     r_wr_addr;
    logic [c_CNT_W-1:0]     r_rd_addr;
    logic [c_CNT_W-1:0]     r_pop_cnt;

    logic                   r_cen;
    logic [NUM-1:0]         r_wen;
    logic [ADDR_W-1:0]      r_a;
    logic [c_WORD_W-1:0]    r_d;
    logic                   r_wr_done;
    logic                   r_rd_done;

    // r_pres: read on the SRAM pins this cycle; r_cap: its data is on sram_q now
    logic                   r_pres;
    logic                   r_cap;

    logic [c_WORD_W-1:0]    r_mem [4];
    logic [1:0]             r_wp;
    logic [1:0]             r_rp;
    logic [2:0]             r_cnt;

    logic                   w_frame_start;
    logic                   w_wr_hs;
    logic                   w_wr_last;
    logic [3:0]             w_occ;
    logic                   w_rd_issue;
    logic                   w_out_valid;
    logic                   w_pop;
    logic                   w_rd_last;
    logic [c_CNT_W-1:0]     w_len_in;

    assign w_len_in      = (bus.frame_len == '0) ? c_CNT_W'(DEPTH) : {1'b0, bus.frame_len};
    assign w_frame_start = (r_state == S_IDLE) && bus.start;
    assign w_wr_hs       = (r_state == S_WRITE) && bus.in_valid;
    assign w_wr_last     = w_wr_hs && (r_wr_addr == r_len - c_CNT_ONE);

    // Credits cover FIFO entries plus the two read-pipeline stages
    assign w_occ         = 4'(r_cnt) + 4'(r_pres) + 4'(r_cap);
    assign w_rd_issue    = ((r_state == S_FULL) && bus.rd_start) ||
                           ((r_state == S_READ) && (r_rd_addr < r_len) && (w_occ < 4'd4));

    assign w_out_valid   = (r_cnt != 3'd0);
    assign w_pop         = w_out_valid && bus.out_ready;
    assign w_rd_last     = w_pop && (r_pop_cnt == r_len - c_CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)    w_state_nxt = S_WRITE;
            S_WRITE: if (w_wr_last)    w_state_nxt = S_FULL;
            S_FULL:  if (bus.rd_start) w_state_nxt = S_READ;
            S_READ:  if (w_rd_last)    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_pop_cnt <= '0;
            r_cen     <= 1'b1;
            r_wen     <= '1;
            r_a       <= '0;
            r_d       <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_pres    <= 1'b0;
            r_cap     <= 1'b0;
        end else begin
            r_wr_done <= w_wr_last;
            r_rd_done <= w_rd_last;
            r_cen     <= 1'b1;
            r_wen     <= '1;
            r_pres    <= w_rd_issue;
            r_cap     <= r_pres;

            if (w_frame_start) begin
                r_len     <= w_len_in;
                r_wr_addr <= '0;
                r_rd_addr <= '0;
                r_pop_cnt <= '0;
            end

            // An all-zero mask still consumes an address slot, it just skips the access
            if (w_wr_hs) begin
                r_cen     <= (bus.in_mask == '0);
                r_wen     <= ~bus.in_mask;
                r_a       <= r_wr_addr[ADDR_W-1:0];
                r_d       <= bus.in_data;
                r_wr_addr <= r_wr_addr + c_CNT_ONE;
            end

            if (w_rd_issue) begin
                r_cen     <= 1'b0;
                r_wen     <= '1;
                r_a       <= r_rd_addr[ADDR_W-1:0];
                r_rd_addr <= r_rd_addr + c_CNT_ONE;
            end

            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) begin
                r_mem[j] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (r_cap) begin
                r_mem[r_wp] <= bus.sram_q;
                r_wp        <= r_wp + 2'd1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 2'd1;
            end
            case ({r_cap, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_WRITE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.wr_done   = r_wr_done;
    assign bus.rd_done   = r_rd_done;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_mem[r_rp];
    assign bus.sram_cen  = r_cen;
    assign bus.sram_wen  = r_wen;
    assign bus.sram_a    = {NUM{r_a}};
    assign bus.sram_d    = r_d;

endmodule
`default_nettype wire

// File: doc/orsram_seq_ctrl.md
# orsram_seq_ctrl

Sequencing controller directly upstream of the output-result SRAM bank array (NUM banks, 128 x 8 each, shared active-low chip enable, per-bank active-low write enable). It accepts a valid/ready stream of NUM-lane output words and writes one frame into the banks at incrementing addresses. On request it streams the same frame back out through a credit-controlled 4-entry output FIFO, which absorbs the SRAM read latency under downstream backpressure.

## Interface
- NUM, default `SRAM_NUM: number of SRAM banks / data lanes
- ADDR_W, default 7: bank address width
- DATA_W, default 8: bank data width
- DEPTH, default 128: words per bank (2^ADDR_W)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin write frame; sampled only in IDLE
- frame_len  in  ADDR_W  words per frame; sampled with start; 0 means DEPTH
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid&&in_ready
- in_data  in  NUM*DATA_W  lane i at bits [(i+1)*DATA_W-1 -: DATA_W]
- in_mask  in  NUM  per-lane write enable (1 = write bank i)
- wr_done  out  1  one-cycle pulse, frame fully written
- rd_start  in  1  begin readback; sampled only in FULL
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  NUM*DATA_W  FIFO head, same lane packing
- rd_done  out  1  one-cycle pulse, last word popped
- busy  out  1  state != IDLE
- sram_cen  out  1  active-low chip enable, shared by all banks
- sram_wen  out  NUM  active-low per-bank write enable
- sram_a  out  NUM*ADDR_W  address, same value replicated to every bank
- sram_d  out  NUM*DATA_W  write data
- sram_q  in  NUM*DATA_W  read data, valid one cycle after a read is presented

## Operation
- States: IDLE -> (start) WRITE -> (last word accepted) FULL -> (rd_start) READ -> (last word popped) IDLE.
- Latched length L = (frame_len==0) ? DEPTH : frame_len; held until return to IDLE.
- WRITE: in_ready=1 (decoded from registered state). Each handshake registers sram_cen=0, sram_wen[i]=~in_mask[i], sram_a=wr_addr, sram_d=in_data for exactly one cycle; wr_addr increments. If in_mask==0, sram_cen stays 1 (no access), but the address still advances and the word counts. No wrap: addresses are 0..L-1.
- Final (L-th) handshake: state -> FULL; in_ready low from the next cycle; wr_done pulses in the cycle the final write is presented.
- READ: issue a read (registered sram_cen=0, sram_wen=all 1, sram_a=rd_addr) when rd_addr<L and fifo_count+inflight<4, where inflight counts reads issued in the previous two cycles and not yet captured. No other condition gates issue. Data on sram_q is pushed into the FIFO at the end of the cycle after presentation.
- FIFO depth 4, by construction never overflows; a push and a pop in the same cycle are both performed.
- After L pops: rd_done pulses in the cycle after the last pop; state -> IDLE.
- Ignored: start outside IDLE; rd_start outside FULL; in_valid outside WRITE.
- Reset (async, any state): state IDLE; in_ready=0, out_valid=0, out_data=0, wr_done=0, rd_done=0, busy=0, sram_cen=1, sram_wen=all 1, sram_a=0, sram_d=0; FIFO and all counters cleared. Reset mid-frame discards the frame.

## Timing
- start sampled at edge 0 -> busy=1 and in_ready=1 in cycle 1.
- Handshake in cycle t -> SRAM write presented in cycle t+1 (the SRAM samples at the end of t+1).
- Readback: rd_start sampled in cycle 0 -> first read presented in cycle 1 -> sram_q valid in cycle 2 -> out_valid=1 in cycle 3.
- With out_ready held at 1: one word per cycle, L words in cycles 3..L+2; rd_done in cycle L+3.
- sram_cen is low only in cycles that present an access; all SRAM outputs are registered.

## Test plan
- NUM=8, start with frame_len=4, words 0x01..0x04 on all lanes with mask 0xFF -> sram_a 0,1,2,3 written with cen=0 and wen=0x00; wr_done on the 4th write cycle; state FULL.
- frame_len=0 -> 128 words written at addresses 0..127, no wrap, then in_ready=0.
- Mask 0xA5 on word 2 -> sram_wen=0x5A for that write; mask 0x00 -> cen stays 1 and the address still advances.
- Readback L=4, out_ready=1 -> out_valid in cycles 3..6 with data matching the written words; rd_done in cycle 7.
- Readback L=16 with out_ready toggling 1/0 -> no lost or duplicated words, FIFO occupancy ≤ 4, cen high while credits are exhausted.
- rst_n asserted mid-WRITE and again mid-READ -> outputs return to their reset values immediately; a new start works normally afterwards.
